// File: rtl/rand_range_sampler_pkg.sv
// Shared definitions for peripherals that consume the LFSR random stream.
// Provides the sample width and the range-to-mask helper.
package rand_pkg;

    localparam int DATA_W = 8;

    // Returns the smallest all-ones value that is >= l, e.g. 5 -> 7, 200 -> 255.
    function automatic logic [DATA_W-1:0] range_mask(input logic [DATA_W-1:0] l);
        logic [DATA_W-1:0] m;
        m = l;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/rand_range_sampler_fifo.sv
// Small synchronous FIFO for accepted samples. A flush takes priority over
// push and pop. A push and a pop may happen in the same cycle while full.
module rand_fifo
    import rand_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DATA_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// Decimates the LFSR byte stream, rejection-samples it into [0, LIMIT] and
// buffers accepted values for back-to-back reads by the MCU.
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int DECIM = 8,
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RANDOM,
    input  logic [DATA_W-1:0] LIMIT_IN,
    input  logic              LIMIT_WE,
    input  logic              RD_STROBE,
    output logic [DATA_W-1:0] RAND_OUT,
    output logic              VALID,
    output logic              FULL
);

    localparam logic [7:0] TICK_AT = 8'(DECIM - 1);

    logic [DATA_W-1:0] limit_q, limit_d;
    logic [7:0]        dcnt_q, dcnt_d;
    logic [DATA_W-1:0] mask, cand;
    logic              tick, accept, empty;

    assign mask   = range_mask(limit_q);
    assign cand   = RANDOM & mask;
    assign tick   = (dcnt_q == TICK_AT);
    assign accept = tick && (cand <= limit_q);

    // A limit write restarts decimation so the first sample under the new
    // mask lands DECIM edges later.
    always_comb begin
        limit_d = limit_q;
        dcnt_d  = tick ? 8'd0 : dcnt_q + 8'd1;
        if (LIMIT_WE) begin
            limit_d = LIMIT_IN;
            dcnt_d  = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            limit_q <= 8'hFF;
            dcnt_q  <= 8'd0;
        end else begin
            limit_q <= limit_d;
            dcnt_q  <= dcnt_d;
        end
    end

    rand_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (accept && !LIMIT_WE),
        .pop_i   (RD_STROBE),
        .flush_i (LIMIT_WE),
        .data_i  (cand),
        .head_o  (RAND_OUT),
        .empty_o (empty),
        .full_o  (FULL)
    );

    assign VALID = !empty;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler with DECIM = 8, DEPTH = 4.
module tb_rand_range_sampler;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RANDOM;
    logic [7:0] LIMIT_IN;
    logic       LIMIT_WE;
    logic       RD_STROBE;
    logic [7:0] RAND_OUT;
    logic       VALID;
    logic       FULL;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    rand_range_sampler #(.DECIM(8), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RANDOM    (RANDOM),
        .LIMIT_IN  (LIMIT_IN),
        .LIMIT_WE  (LIMIT_WE),
        .RD_STROBE (RD_STROBE),
        .RAND_OUT  (RAND_OUT),
        .VALID     (VALID),
        .FULL      (FULL)
    );

    typedef struct {
        logic [7:0] limit;
        logic [7:0] rnd;
        logic       exp_valid;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    // Inputs change 1 time unit after a rising edge; outputs are compared there too.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic f, input logic [7:0] d);
        chk({name, ".valid"}, {7'd0, VALID}, {7'd0, v});
        chk({name, ".full"},  {7'd0, FULL},  {7'd0, f});
        chk({name, ".data"},  RAND_OUT, d);
    endtask

    task automatic load_limit(input logic [7:0] l);
        LIMIT_IN = l;
        LIMIT_WE = 1'b1;
        step(1);
        LIMIT_WE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RANDOM = 8'h00; LIMIT_IN = 8'h00; LIMIT_WE = 1'b0; RD_STROBE = 1'b0;
        #1;
        step(3);
        chk_out("reset", 1'b0, 1'b0, 8'h00);

        // Fill from reset with RANDOM = A7 and the default limit of FF.
        RANDOM = 8'hA7;
        RST = 1'b0;
        step(7);
        chk_out("first_edge7", 1'b0, 1'b0, 8'h00);
        step(1);
        chk_out("first_edge8", 1'b1, 1'b0, 8'hA7);
        step(23);
        chk_out("fill_edge31", 1'b1, 1'b0, 8'hA7);
        step(1);
        chk_out("fill_edge32", 1'b1, 1'b1, 8'hA7);

        // Single-sample vectors: load limit, hold RANDOM, check the DECIM-th edge.
        vecs.push_back('{8'hFF, 8'hA7, 1'b1, 8'hA7});
        vecs.push_back('{8'h05, 8'h0E, 1'b0, 8'h00});
        vecs.push_back('{8'h05, 8'h13, 1'b1, 8'h03});
        vecs.push_back('{8'h00, 8'h5A, 1'b1, 8'h00});
        vecs.push_back('{8'hC8, 8'hF0, 1'b0, 8'h00});
        vecs.push_back('{8'hC8, 8'hC8, 1'b1, 8'hC8});
        vecs.push_back('{8'h10, 8'h3F, 1'b0, 8'h00});
        vecs.push_back('{8'h10, 8'h30, 1'b1, 8'h10});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 8'h7F});
        vecs.push_back('{8'h06, 8'hFE, 1'b1, 8'h06});
        vecs.push_back('{8'h06, 8'hFF, 1'b0, 8'h00});
        foreach (vecs[i]) begin
            RANDOM = vecs[i].rnd;
            load_limit(vecs[i].limit);
            chk_out($sformatf("vec%0d_flush", i), 1'b0, 1'b0, 8'h00);
            step(7);
            chk_out($sformatf("vec%0d_pre", i), 1'b0, 1'b0, 8'h00);
            step(1);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, 1'b0, vecs[i].exp_out);
        end

        // Limit 05 with alternating 0E / 13 across ticks: only 03 enters.
        load_limit(8'h05);
        for (int t = 0; t < 4; t++) begin
            RANDOM = t[0] ? 8'h13 : 8'h0E;
            step(8);
        end
        RD_STROBE = 1'b1;
        step(1);
        chk_out("alt_pop1", 1'b1, 1'b0, 8'h03);
        step(1);
        chk_out("alt_pop2", 1'b0, 1'b0, 8'h00);
        RD_STROBE = 1'b0;

        // Limit 00 with a changing random stream: every tick pushes 00.
        load_limit(8'h00);
        for (int t = 1; t <= 4; t++) begin
            for (int e = 0; e < 8; e++) begin
                RANDOM = 8'($urandom_range(255));
                step(1);
            end
            chk_out($sformatf("zero_tick%0d", t), 1'b1, (t == 4), 8'h00);
        end

        // Full FIFO of 11, then pop coinciding with a tick carrying 22.
        RANDOM = 8'h11;
        load_limit(8'hFF);
        step(32);
        chk_out("full11", 1'b1, 1'b1, 8'h11);
        RANDOM = 8'h22;
        step(7);
        RD_STROBE = 1'b1;
        step(1);
        chk_out("pushpop_full", 1'b1, 1'b1, 8'h11);
        step(1);
        chk_out("pop2", 1'b1, 1'b0, 8'h11);
        step(1);
        chk_out("pop3", 1'b1, 1'b0, 8'h11);
        step(1);
        chk_out("pop4_tail", 1'b1, 1'b0, 8'h22);
        step(1);
        chk_out("pop5_empty", 1'b0, 1'b0, 8'h00);
        step(1);
        chk_out("pop_while_empty", 1'b0, 1'b0, 8'h00);
        RD_STROBE = 1'b0;
        step(2);
        chk_out("empty_hold", 1'b0, 1'b0, 8'h00);
        step(1);
        chk_out("after_empty_push", 1'b1, 1'b0, 8'h22);
        RD_STROBE = 1'b1;
        step(1);
        RD_STROBE = 1'b0;
        chk_out("no_underflow", 1'b0, 1'b0, 8'h00);

        // LIMIT_WE on a tick with a pop pending and two buffered entries.
        RANDOM = 8'h33;
        load_limit(8'hFF);
        step(16);
        chk_out("two_buf", 1'b1, 1'b0, 8'h33);
        step(7);
        RANDOM    = 8'h44;
        LIMIT_IN  = 8'hFF;
        LIMIT_WE  = 1'b1;
        RD_STROBE = 1'b1;
        step(1);
        LIMIT_WE  = 1'b0;
        RD_STROBE = 1'b0;
        chk_out("we_on_tick", 1'b0, 1'b0, 8'h00);
        step(7);
        chk_out("we_tick_pre", 1'b0, 1'b0, 8'h00);
        step(1);
        chk_out("we_tick_next", 1'b1, 1'b0, 8'h44);

        // RST mid-fill under limit 05, then the limit must be back to FF.
        RANDOM = 8'h13;
        load_limit(8'h05);
        step(8);
        chk_out("pre_rst", 1'b1, 1'b0, 8'h03);
        step(3);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk_out("rst_mid", 1'b0, 1'b0, 8'h00);
        RANDOM = 8'hF7;
        step(7);
        chk_out("rst_pre", 1'b0, 1'b0, 8'h00);
        step(1);
        chk_out("rst_limit_ff", 1'b1, 1'b0, 8'hF7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rand_range_sampler.md
# rand_range_sampler

Post-processing stage directly downstream of the 32-bit LFSR random generator in the RAT MCU peripheral set. It decimates the LFSR's 8-bit output stream so each sample is built from fresh shift bits, and constrains samples to a software-programmed inclusive range [0, LIMIT] by masking and rejection sampling. Accepted values are buffered in a small FIFO so the MCU can read them back-to-back through an IN port with a single-strobe consume handshake.

## Interface
Parameters:
- DECIM, 8: cycles between samples; legal range 1..255. The default 8 gives 8 fresh LFSR bits per sample.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.

Ports:
- CLK  in  1  system clock (100 MHz); the only clock.
- RST  in  1  reset, synchronous and active-high.
- RANDOM  in  8  raw LFSR output, sampled only on decimation ticks.
- LIMIT_IN  in  8  new inclusive upper bound.
- LIMIT_WE  in  1  one-cycle MCU OUT-port strobe that loads LIMIT_IN.
- RD_STROBE  in  1  one-cycle MCU IN-port strobe that consumes the FIFO head.
- RAND_OUT  out  8  FIFO head; reads 8'h00 when empty.
- VALID  out  1  FIFO non-empty.
- FULL  out  1  FIFO holds DEPTH entries.

## Operation
- Reset state:
  - LIMIT register = 8'hFF; mask = 8'hFF.
  - Decimation counter = 0; FIFO count = 0; read and write pointers = 0.
  - RAND_OUT = 8'h00, VALID = 0, FULL = 0.
- Decimation counter:
  - Counts 0..DECIM-1 and wraps.
  - A tick occurs on any cycle where the counter equals DECIM-1.
  - With DECIM = 1, every cycle is a tick.
- Mask: smallest all-ones value that is at least LIMIT, i.e. L | L>>1 | L>>2 | L>>4 | L>>8 truncated to 8 bits. Examples: LIMIT 0 gives mask 0; LIMIT 5 gives 7; LIMIT 200 gives 255.
- Candidate: RANDOM & mask, unsigned 8-bit.
- On a tick:
  - Accept the candidate if candidate ≤ LIMIT.
  - Otherwise reject it. No retry occurs before the next tick.
- Push: an accepted candidate is written when the FIFO is not full, or when it is full and a valid pop happens in the same cycle.
  - Any other accepted candidate is discarded silently.
- Pop: RD_STROBE with VALID = 1 advances the read pointer. RD_STROBE while empty is ignored.
- LIMIT_WE:
  - Loads LIMIT_IN.
  - Flushes the FIFO: count = 0 and both pointers = 0.
  - Clears the decimation counter to 0.
  - Highest priority. It overrides a push or pop in the same cycle, and the candidate in that cycle is dropped.
  - The new mask applies from the next tick onward.
- Priority order: RST > LIMIT_WE > push/pop.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Timing
- All state updates on the rising edge of CLK. RST and LIMIT_WE are sampled on that edge.
- RAND_OUT, VALID and FULL are registered or decoded only from registered state. No combinational path exists from any input to any output.
- Push latency: an accepted candidate on tick edge N is visible on RAND_OUT/VALID after edge N, provided the FIFO was empty.
- Pop: after the RD_STROBE edge, RAND_OUT shows the next entry, or 8'h00 with VALID = 0 if the FIFO is now empty.
- First sample after reset release or after LIMIT_WE: taken on the DECIM-th subsequent edge.
- Asserting RST mid-stream discards all buffered data on that edge. Outputs return to their reset values after that edge.

## Structure
- Package rand_pkg:
  - DATA_W = 8.
  - Function range_mask(logic [7:0]) returning the mask.
  - Reused later by other random-consuming peripherals.
- Sub-module rand_fifo:
  - Parameterised synchronous FIFO: DEPTH × DATA_W.
  - Signals: push, pop, flush, data in, head out, empty, full.
  - Flush has priority over push and pop.
  - Same-cycle push and pop when full is legal.
- The top level holds the LIMIT register, the decimation counter and the accept logic.

## Test plan
- Reset, then RANDOM held at 8'hA7, DECIM = 8, LIMIT = 8'hFF: VALID rises after the 8th edge with RAND_OUT = 8'hA7; FULL is set after edge 32.
- LIMIT_WE with 8'h05, then RANDOM alternating 8'h0E and 8'h13 across ticks:
  - 8'h0E gives candidate 6, which is rejected.
  - 8'h13 gives candidate 3, which is accepted.
  - Only 8'h03 values enter the FIFO.
- LIMIT = 8'h00, random RANDOM stream: every tick pushes 8'h00.
- FIFO full (4 × 8'h11), then RANDOM = 8'h22 with RD_STROBE coinciding with a tick:
  - The pop and the push both occur.
  - Count stays 4 and FULL stays 1.
  - RAND_OUT = 8'h11 until the 4th pop, after which the tail 8'h22 is at the head.
- RD_STROBE while empty: no state change, RAND_OUT = 8'h00, count does not underflow.
- LIMIT_WE coinciding with a tick, a RD_STROBE and 2 buffered entries:
  - FIFO is flushed, VALID = 0 and the candidate is dropped.
  - The next push occurs DECIM edges later.
- RST asserted mid-fill: all outputs are at reset values after the edge, and LIMIT reverts to 8'hFF.
